// File: rtl/ipdbg_hub_pkg.sv
// Shared constants for the IPDBG channel hub: well-known channel IDs,
// the default ID table and a constant-friendly clog2.
package ipdbg_hub_pkg;

    localparam logic [3:0] ID_LA     = 4'hC;
    localparam logic [3:0] ID_IOVIEW = 4'hA;
    localparam logic [3:0] ID_GDB    = 4'h9;
    localparam logic [3:0] ID_WFG    = 4'hB;

    // Channel i takes slice [i*4 +: 4], so LA sits at index 0.
    localparam logic [15:0] DEFAULT_CH_IDS = {ID_WFG, ID_GDB, ID_IOVIEW, ID_LA};

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ipdbg_hub_up_fifo.sv
// Per-channel upstream FIFO with show-ahead read data; DEPTH must be a
// power of two so the pointers wrap naturally.
module ipdbg_hub_up_fifo
    import ipdbg_hub_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              empty_o
);

    localparam int AW = clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       cnt_q;
    logic              full, wr_en, rd_en;

    assign full       = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign wr_ready_o = ce & ~full;
    assign wr_en      = wr_valid_i & wr_ready_o;
    assign rd_en      = rd_en_i & ~empty_o & ce;
    assign rd_data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // A full FIFO never writes, so read+write on full only drains one entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ipdbg_channel_hub.sv
// Host-link <-> IP-core channel hub: ID-decoded downstream hold register,
// per-channel upstream FIFOs with round-robin merge. Optional drop counter
// enabled by defining IPDBG_HUB_DROP_CNT_EN.
module ipdbg_channel_hub
    import ipdbg_hub_pkg::*;
#(
    parameter int                         CHANNELS = 4,
    parameter int                         DATA_W   = 8,
    parameter int                         ID_W     = 4,
    parameter logic [CHANNELS*ID_W-1:0]   CH_IDS   = DEFAULT_CH_IDS,
    parameter int                         UP_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  logic                         host_dwn_valid,
    output logic                         host_dwn_ready,
    input  logic [ID_W-1:0]              host_dwn_id,
    input  logic [DATA_W-1:0]            host_dwn_data,
    output logic [DATA_W-1:0]            data_dwn,
    output logic [CHANNELS-1:0]          data_dwn_valid,
    input  logic [CHANNELS-1:0]          data_dwn_ready,
    input  logic [CHANNELS*DATA_W-1:0]   data_up,
    input  logic [CHANNELS-1:0]          data_up_valid,
    output logic [CHANNELS-1:0]          data_up_ready,
    output logic                         host_up_valid,
    input  logic                         host_up_ready,
    output logic [ID_W-1:0]              host_up_id,
    output logic [DATA_W-1:0]            host_up_data
`ifdef IPDBG_HUB_DROP_CNT_EN
    ,
    output logic [7:0]                   drop_cnt
`endif
);

    localparam int IDX_W = (CHANNELS > 1) ? clog2(CHANNELS) : 1;

    logic                dec_hit;
    logic [CHANNELS-1:0] dec_oh;
    logic [CHANNELS-1:0] dwn_oh_q;
    logic [DATA_W-1:0]   dwn_data_q;
    logic                dwn_consume, dwn_accept;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_oh  = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (host_dwn_id == CH_IDS[i*ID_W +: ID_W]) begin
                dec_hit   = 1'b1;
                dec_oh    = '0;
                dec_oh[i] = 1'b1;
            end
        end
    end

    assign dwn_consume    = (|(dwn_oh_q & data_dwn_ready)) & ce;
    assign host_dwn_ready = ce & (~(|dwn_oh_q) | dwn_consume);
    assign dwn_accept     = host_dwn_valid & host_dwn_ready;
    assign data_dwn       = dwn_data_q;
    assign data_dwn_valid = dwn_oh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dwn_oh_q   <= '0;
            dwn_data_q <= '0;
        end else if (ce) begin
            if (dwn_accept && dec_hit) begin
                dwn_oh_q   <= dec_oh;
                dwn_data_q <= host_dwn_data;
            end else if (dwn_consume) begin
                dwn_oh_q <= '0;
            end
        end
    end

    logic [DATA_W-1:0]   fifo_data [CHANNELS];
    logic [CHANNELS-1:0] fifo_empty;
    logic [CHANNELS-1:0] fifo_rd;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_up
        ipdbg_hub_up_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (UP_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .ce         (ce),
            .wr_valid_i (data_up_valid[g]),
            .wr_data_i  (data_up[g*DATA_W +: DATA_W]),
            .wr_ready_o (data_up_ready[g]),
            .rd_en_i    (fifo_rd[g]),
            .rd_data_o  (fifo_data[g]),
            .empty_o    (fifo_empty[g])
        );
    end

    logic              up_valid_q, up_valid_d;
    logic [ID_W-1:0]   up_id_q, up_id_d;
    logic [DATA_W-1:0] up_data_q, up_data_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  arb_c, grant_idx;
    logic              grant_valid, up_consume, up_load_ok;

    assign up_consume = up_valid_q & host_up_ready & ce;
    assign up_load_ok = ce & (~up_valid_q | up_consume);

    // First non-empty FIFO at or after the round-robin pointer.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        arb_c       = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            arb_c = IDX_W'((int'(rr_q) + k) % CHANNELS);
            if (!fifo_empty[arb_c]) begin
                grant_valid = 1'b1;
                grant_idx   = arb_c;
            end
        end
    end

    always_comb begin
        fifo_rd    = '0;
        up_valid_d = up_valid_q;
        up_id_d    = up_id_q;
        up_data_d  = up_data_q;
        rr_d       = rr_q;
        if (up_load_ok && grant_valid) begin
            fifo_rd[grant_idx] = 1'b1;
            up_valid_d         = 1'b1;
            up_id_d            = CH_IDS[grant_idx*ID_W +: ID_W];
            up_data_d          = fifo_data[grant_idx];
            rr_d               = IDX_W'((int'(grant_idx) + 1) % CHANNELS);
        end else if (up_consume) begin
            up_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_valid_q <= 1'b0;
            up_id_q    <= '0;
            up_data_q  <= '0;
            rr_q       <= '0;
        end else if (ce) begin
            up_valid_q <= up_valid_d;
            up_id_q    <= up_id_d;
            up_data_q  <= up_data_d;
            rr_q       <= rr_d;
        end
    end

    assign host_up_valid = up_valid_q;
    assign host_up_id    = up_id_q;
    assign host_up_data  = up_data_q;

`ifdef IPDBG_HUB_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (dwn_accept && !dec_hit && drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ipdbg_channel_hub.sv
// Directed bench for ipdbg_channel_hub: downstream/upstream scoreboards fed
// by the stimulus thread and drained by monitors on the falling edge.
module tb_ipdbg_channel_hub;
  import ipdbg_hub_pkg::*;

  localparam int CH = 4;
  localparam int DW = 8;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst, ce;
  logic host_dwn_valid, host_dwn_ready;
  logic [IW-1:0] host_dwn_id;
  logic [DW-1:0] host_dwn_data, data_dwn;
  logic [CH-1:0] data_dwn_valid, data_dwn_ready;
  logic [CH*DW-1:0] data_up;
  logic [CH-1:0] data_up_valid, data_up_ready;
  logic host_up_valid, host_up_ready;
  logic [IW-1:0] host_up_id;
  logic [DW-1:0] host_up_data;
`ifdef IPDBG_HUB_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_tests = 0;
  int n_fail = 0;

  logic [CH+DW-1:0] exp_dn_q[$];
  logic [IW+DW-1:0] exp_up_q[$];

  always #5 clk = ~clk;

  ipdbg_channel_hub dut (
    .clk            (clk),
    .rst            (rst),
    .ce             (ce),
    .host_dwn_valid (host_dwn_valid),
    .host_dwn_ready (host_dwn_ready),
    .host_dwn_id    (host_dwn_id),
    .host_dwn_data  (host_dwn_data),
    .data_dwn       (data_dwn),
    .data_dwn_valid (data_dwn_valid),
    .data_dwn_ready (data_dwn_ready),
    .data_up        (data_up),
    .data_up_valid  (data_up_valid),
    .data_up_ready  (data_up_ready),
    .host_up_valid  (host_up_valid),
    .host_up_ready  (host_up_ready),
    .host_up_id     (host_up_id),
    .host_up_data   (host_up_data)
`ifdef IPDBG_HUB_DROP_CNT_EN
    ,
    .drop_cnt       (drop_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream monitor: every completed channel handshake pops one entry.
  always @(negedge clk) begin
    if (!rst && ce && ((data_dwn_valid & data_dwn_ready) != '0)) begin
      if (exp_dn_q.size() == 0) begin
        check("dn_unexpected", {20'd0, data_dwn_valid, data_dwn}, 32'hFFFF_FFFF);
      end else begin
        check("dn_frame", {20'd0, data_dwn_valid, data_dwn}, {20'd0, exp_dn_q.pop_front()});
      end
    end
  end

  // Upstream monitor: every host handshake pops one {id, data} entry.
  always @(negedge clk) begin
    if (!rst && ce && host_up_valid && host_up_ready) begin
      if (exp_up_q.size() == 0) begin
        check("up_unexpected", {20'd0, host_up_id, host_up_data}, 32'hFFFF_FFFF);
      end else begin
        check("up_frame", {20'd0, host_up_id, host_up_data}, {20'd0, exp_up_q.pop_front()});
      end
    end
  end

  initial begin
    rst = 1'b1; ce = 1'b1;
    host_dwn_valid = 1'b0; host_dwn_id = '0; host_dwn_data = '0;
    data_dwn_ready = '0; data_up = '0; data_up_valid = '0; host_up_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_dwn_valid", 32'(data_dwn_valid), 0);
    check("rst_dwn_data", 32'(data_dwn), 0);
    check("rst_up_valid", 32'(host_up_valid), 0);
    check("rst_up_id", 32'(host_up_id), 0);
    check("rst_up_data", 32'(host_up_data), 0);
    tick();
    rst = 1'b0;

    // Back-to-back downstream frames to IOView then GDB.
    data_dwn_ready = 4'hF;
    host_dwn_valid = 1'b1; host_dwn_id = 4'hA; host_dwn_data = 8'h55;
    exp_dn_q.push_back({4'b0010, 8'h55});
    @(negedge clk);
    check("t1_ready_a", 32'(host_dwn_ready), 1);
    tick();
    host_dwn_id = 4'h9; host_dwn_data = 8'h12;
    exp_dn_q.push_back({4'b0100, 8'h12});
    @(negedge clk);
    check("t1_valid_a", 32'(data_dwn_valid), 32'h2);
    check("t1_data_a", 32'(data_dwn), 32'h55);
    check("t1_ready_b", 32'(host_dwn_ready), 1);
    tick();
    host_dwn_valid = 1'b0;
    @(negedge clk);
    check("t1_valid_b", 32'(data_dwn_valid), 32'h4);
    check("t1_data_b", 32'(data_dwn), 32'h12);
    tick();
    @(negedge clk);
    check("t1_idle", 32'(data_dwn_valid), 0);

    // Backpressure on LA: second frame waits until the first drains.
    data_dwn_ready = 4'b1110;
    host_dwn_valid = 1'b1; host_dwn_id = 4'hC; host_dwn_data = 8'h01;
    exp_dn_q.push_back({4'b0001, 8'h01});
    tick();
    host_dwn_data = 8'h02;
    exp_dn_q.push_back({4'b0001, 8'h02});
    @(negedge clk);
    check("t2_ready_held", 32'(host_dwn_ready), 0);
    check("t2_valid", 32'(data_dwn_valid), 32'h1);
    check("t2_data_first", 32'(data_dwn), 32'h01);
    tick();
    @(negedge clk);
    check("t2_data_stable", 32'(data_dwn), 32'h01);
    tick();
    data_dwn_ready = 4'hF;
    @(negedge clk);
    check("t2_ready_release", 32'(host_dwn_ready), 1);
    tick();
    data_dwn_ready = 4'b1110; host_dwn_valid = 1'b0;
    @(negedge clk);
    check("t2_data_second", 32'(data_dwn), 32'h02);
    check("t2_valid_second", 32'(data_dwn_valid), 32'h1);
    tick();
    data_dwn_ready = 4'hF;
    tick();
    @(negedge clk);
    check("t2_idle", 32'(data_dwn_valid), 0);

    // Unmatched ID is swallowed without any channel pulse.
    host_dwn_valid = 1'b1; host_dwn_id = 4'h7; host_dwn_data = 8'hAA;
    tick();
    host_dwn_valid = 1'b0;
    @(negedge clk);
    check("t5_no_pulse", 32'(data_dwn_valid), 0);
`ifdef IPDBG_HUB_DROP_CNT_EN
    check("t5_drop_one", 32'(drop_cnt), 1);
`endif
    tick();
    host_dwn_valid = 1'b1;
    repeat (299) tick();
    host_dwn_valid = 1'b0;
    @(negedge clk);
    check("t5_no_pulse_burst", 32'(data_dwn_valid), 0);
`ifdef IPDBG_HUB_DROP_CNT_EN
    check("t5_drop_sat", 32'(drop_cnt), 32'hFF);
`endif
    tick();

    // All channels at once: round-robin from pointer 0.
    host_up_ready = 1'b1;
    data_up = {8'h13, 8'h12, 8'h11, 8'h10};
    data_up_valid = 4'hF;
    exp_up_q.push_back({4'hC, 8'h10});
    exp_up_q.push_back({4'hA, 8'h11});
    exp_up_q.push_back({4'h9, 8'h12});
    exp_up_q.push_back({4'hB, 8'h13});
    @(negedge clk);
    check("t3_up_ready", 32'(data_up_ready), 32'hF);
    tick();
    data_up_valid = '0;
    @(negedge clk);
    check("t3_latency_n", 32'(host_up_valid), 0);
    tick();
    @(negedge clk);
    check("t3_latency_n1", 32'(host_up_valid), 1);
    check("t3_first_id", 32'(host_up_id), 32'hC);
    repeat (4) tick();
    @(negedge clk);
    check("t3_drained", 32'(host_up_valid), 0);
    // Pointer back at 0: LA must win over IOView.
    data_up = {8'h00, 8'h00, 8'h41, 8'h40};
    data_up_valid = 4'b0011;
    exp_up_q.push_back({4'hC, 8'h40});
    exp_up_q.push_back({4'hA, 8'h41});
    tick();
    data_up_valid = '0;
    repeat (4) tick();

    // Upstream backpressure fills FIFO plus output register.
    host_up_ready = 1'b0;
    data_up_valid = 4'b0001;
    foreach (exp_up_q[i]) begin end
    for (int b = 0; b < 3; b++) begin
      data_up[7:0] = 8'(8'h21 + b);
      exp_up_q.push_back({4'hC, 8'(8'h21 + b)});
      tick();
    end
    data_up_valid = '0;
    @(negedge clk);
    check("t4_ready_low", 32'(data_up_ready), 32'hE);
    check("t4_out_valid", 32'(host_up_valid), 1);
    check("t4_out_data", 32'(host_up_data), 32'h21);
    repeat (3) tick();
    @(negedge clk);
    check("t4_out_stable", 32'(host_up_data), 32'h21);
    check("t4_ready_still_low", 32'(data_up_ready), 32'hE);
    host_up_ready = 1'b1;
    repeat (5) tick();

    // Clock-enable freeze followed by reset with a pending frame.
    host_up_ready = 1'b0; data_dwn_ready = '0;
    host_dwn_valid = 1'b1; host_dwn_id = 4'hA; host_dwn_data = 8'h44;
    data_up[15:8] = 8'h31; data_up_valid = 4'b0010;
    tick();
    host_dwn_valid = 1'b0; data_up[15:8] = 8'h32;
    tick();
    data_up_valid = '0;
    tick();
    @(negedge clk);
    check("t6_pre_up_valid", 32'(host_up_valid), 1);
    check("t6_pre_up_data", 32'(host_up_data), 32'h31);
    check("t6_pre_dn_valid", 32'(data_dwn_valid), 32'h2);
    tick();
    ce = 1'b0; host_up_ready = 1'b1; data_dwn_ready = 4'hF;
    host_dwn_valid = 1'b1; host_dwn_id = 4'h9; host_dwn_data = 8'h77;
    data_up_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t6_frz_up_valid", 32'(host_up_valid), 1);
      check("t6_frz_up_data", 32'(host_up_data), 32'h31);
      check("t6_frz_dn_valid", 32'(data_dwn_valid), 32'h2);
      check("t6_frz_dn_data", 32'(data_dwn), 32'h44);
      check("t6_frz_dwn_ready", 32'(host_dwn_ready), 0);
      check("t6_frz_up_ready", 32'(data_up_ready), 0);
      tick();
    end
    host_dwn_valid = 1'b0; data_up_valid = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0; ce = 1'b1;
    @(negedge clk);
    check("t6_rst_dn_valid", 32'(data_dwn_valid), 0);
    check("t6_rst_dn_data", 32'(data_dwn), 0);
    check("t6_rst_up_valid", 32'(host_up_valid), 0);
    check("t6_rst_up_id", 32'(host_up_id), 0);
    check("t6_rst_up_data", 32'(host_up_data), 0);
    check("t6_rst_up_ready", 32'(data_up_ready), 32'hF);
    check("t6_rst_dwn_ready", 32'(host_dwn_ready), 1);
    repeat (3) tick();
    @(negedge clk);
    check("t6_fifo_empty", 32'(host_up_valid), 0);

    for (int w = 0; w < 50 && (exp_dn_q.size() != 0 || exp_up_q.size() != 0); w++) tick();
    check("dn_queue_drained", 32'(exp_dn_q.size()), 0);
    check("up_queue_drained", 32'(exp_up_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
